// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// The FSM state encoding and the requester count live here for the top level and the picker.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first asserted request at or after i_ptr.
// The scan wraps from 3 back to 0.
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [1:0]       o_winner,
    output logic             o_any
);

    logic [N_REQ-1:0] w_rot;
    logic [1:0]       w_off;

    // Rotate the request vector so that bit k is requester (ptr + k) mod 4.
    assign w_rot = 4'({i_req, i_req} >> i_ptr);

    // NOTE: a default assignment at the top of always_comb keeps this block free of inferred latches.
    always_comb begin
        w_off = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 2'(k);
            end
        end
    end

    assign o_winner = i_ptr + w_off;
    assign o_any    = |i_req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// Each ownership is followed by one turnaround cycle. MAX_HOLD > 0 bounds how long one owner can hold the mux.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [1:0]       SEL,
    output logic             VALID
);

    localparam logic [HOLD_W-1:0] CNT_SAT   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [HOLD_W-1:0] r_cnt;
    logic [N_REQ-1:0]  r_gnt;
    logic [1:0]        r_sel;
    logic              r_valid;

    logic [1:0]        w_winner;
    logic              w_any;
    logic              w_release;

    rr_pick4 u_pick (
        .i_req    (REQ),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // r_sel always holds the current owner while in GRANT.
    assign w_release = DONE
                    || !REQ[r_sel]
                    || ((MAX_HOLD != 0) && (r_cnt == HOLD_LAST));

    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, TURN: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= onehot4(w_winner);
                        r_sel   <= w_winner;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + HOLD_W'(1);
                    end
                    // SEL keeps the departing owner through the turnaround cycle.
                    if (w_release) begin
                        r_state <= TURN;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_ptr   <= r_sel + 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign SEL   = r_sel;
    assign VALID = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random traffic.
// All cycles are checked against a transaction-level ownership model.
module tb_rr_mux_arbiter;

    localparam int TB_MAX_HOLD = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       VALID;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the mux, for how many cycles, and who is next in line.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_sel   = 0;

    rr_mux_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .HOLD_W(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DONE  (DONE),
        .GNT   (GNT),
        .SEL   (SEL),
        .VALID (VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] req, input logic done, input logic rst);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_sel   = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (done || !req[m_owner] || (TB_MAX_HOLD > 0 && m_held == TB_MAX_HOLD)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i;
                    m_sel   = i;
                    m_held  = 0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare all outputs.
    task automatic cycle(input logic [3:0] req, input logic done, input logic rst);
        logic [3:0] exp_gnt;
        @(negedge CLK);
        REQ  = req;
        DONE = done;
        RST  = rst;
        @(posedge CLK);
        model_step(req, done, rst);
        #1;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check("model_gnt", 32'(GNT), 32'(exp_gnt));
        check("model_sel", 32'(SEL), 32'(m_sel));
        check("model_valid", 32'(VALID), 32'(m_owner >= 0));
    endtask

    initial begin
        logic [3:0] req;
        RST  = 1'b1;
        REQ  = 4'b0000;
        DONE = 1'b0;

        // Reset state
        cycle(4'b0000, 1'b0, 1'b1);
        check("rst_gnt", 32'(GNT), 32'h0);
        check("rst_sel", 32'(SEL), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);

        // 1: single requester, one-cycle latency, DONE release
        cycle(4'b0001, 1'b0, 1'b0);
        check("t1_gnt", 32'(GNT), 32'h1);
        check("t1_valid", 32'(VALID), 32'h1);
        cycle(4'b0001, 1'b1, 1'b0);
        check("t1_rel_gnt", 32'(GNT), 32'h0);
        check("t1_rel_sel", 32'(SEL), 32'h0);

        // 2: all requesting, DONE on third grant cycle -> order 0,1,2,3,0
        cycle(4'b0000, 1'b0, 1'b1);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                cycle(4'b1111, 1'b0, 1'b0);
                check("t2_gnt", 32'(GNT), 32'(1 << (g % 4)));
                check("t2_sel", 32'(SEL), 32'(g % 4));
            end
            cycle(4'b1111, 1'b1, 1'b0);
            check("t2_gap", 32'(GNT), 32'h0);
        end

        // 3: hold timeout after exactly MAX_HOLD cycles
        cycle(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            logic [3:0] e;
            e = (c < 4) ? 4'b0010 : (c >= 5 && c < 9) ? 4'b0100 : 4'b0000;
            cycle(4'b0110, 1'b0, 1'b0);
            check("t3_gnt", 32'(GNT), 32'(e));
        end

        // 4: pointer wrap from owner 3 back to 0
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b0);
        check("t4_own3", 32'(GNT), 32'h8);
        cycle(4'b1000, 1'b1, 1'b0);
        check("t4_turn_sel", 32'(SEL), 32'h3);
        cycle(4'b1001, 1'b0, 1'b0);
        check("t4_wrap", 32'(GNT), 32'h1);
        check("t4_wrap_sel", 32'(SEL), 32'h0);

        // 5: reset mid-grant clears outputs and pointer
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        check("t5_own1", 32'(GNT), 32'h2);
        cycle(4'b0010, 1'b0, 1'b1);
        check("t5_rst_gnt", 32'(GNT), 32'h0);
        check("t5_rst_sel", 32'(SEL), 32'h0);
        check("t5_rst_valid", 32'(VALID), 32'h0);
        cycle(4'b0101, 1'b0, 1'b0);
        check("t5_ptr0", 32'(GNT), 32'h1);

        // 6: owner drops its request, next grant scans from 3 and wraps to 0
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        check("t6_own2", 32'(GNT), 32'h4);
        cycle(4'b0000, 1'b0, 1'b0);
        check("t6_drop", 32'(GNT), 32'h0);
        cycle(4'b0001, 1'b0, 1'b0);
        check("t6_next", 32'(GNT), 32'h1);

        // Random traffic with sticky requests so timeouts and drops both occur
        req = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                req = 4'($urandom_range(0, 15));
            end
            cycle(req, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
